// File: rtl/piezo_pkg.sv
// Shared types, pad count and constant helpers for the piezo tone driver.
package piezo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int NUM_PADS = 4;

  typedef logic [1:0] pad_idx_t;

  // Repeated addition keeps the pitch table free of any multiplier.
  function automatic int hp_of(int base, int step, int idx);
    int hp = base;
    for (int i = 0; i < idx; i++) begin
      hp += step;
    end
    return hp;
  endfunction

  function automatic int cnt_width(int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/drum_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for the raw pad levels.
module drum_sync_edge
  import piezo_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PADS-1:0] drum,
  output logic [NUM_PADS-1:0] hit
);

  logic [NUM_PADS-1:0] s1_q, s1_d;
  logic [NUM_PADS-1:0] s2_q, s2_d;
  logic [NUM_PADS-1:0] prev_q, prev_d;
  logic [1:0]          settle_q, settle_d;

  // Edges are suppressed until prev holds a post-reset sample, so a pad held through reset is not a hit.
  always_comb begin
    s1_d     = drum;
    s2_d     = s1_q;
    prev_d   = s2_q;
    settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      prev_q   <= '0;
      settle_q <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
    end
  end

  assign hit = (settle_q == 2'd3) ? (s2_q & ~prev_q) : '0;

endmodule

// File: rtl/piezo_tone_driver.sv
// Pad hits to a single arbitrated square-wave tone with LED indication.
// Optional per-pad hit lockout is enabled by defining PIEZO_DEBOUNCE_EN.
module piezo_tone_driver
  import piezo_pkg::*;
#(
  parameter int HP_BASE    = 25000,
  parameter int HP_STEP    = 5000,
  parameter int DUR_CYCLES = 5000000,
  parameter int GAP_CYCLES = 500000
`ifdef PIEZO_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES = 1000000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] drum,
  output logic       piezo,
  output logic [3:0] led,
  output logic       busy
);

  localparam int HP_MAX = hp_of(HP_BASE, HP_STEP, NUM_PADS - 1);
  localparam int HP_W   = cnt_width(HP_MAX);
  localparam int DUR_W  = cnt_width(DUR_CYCLES);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);

  localparam logic [HP_W-1:0]  HP_LAST0 = HP_W'(hp_of(HP_BASE, HP_STEP, 0) - 1);
  localparam logic [HP_W-1:0]  HP_LAST1 = HP_W'(hp_of(HP_BASE, HP_STEP, 1) - 1);
  localparam logic [HP_W-1:0]  HP_LAST2 = HP_W'(hp_of(HP_BASE, HP_STEP, 2) - 1);
  localparam logic [HP_W-1:0]  HP_LAST3 = HP_W'(hp_of(HP_BASE, HP_STEP, 3) - 1);
  localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [NUM_PADS-1:0] hit, hit_ok;
  logic                win_valid;
  pad_idx_t            win_idx;

  state_t           state_q, state_d;
  pad_idx_t         pad_q, pad_d;
  logic [HP_W-1:0]  hp_cnt_q, hp_cnt_d;
  logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             piezo_q, piezo_d;
  logic [HP_W-1:0]  hp_last;
  logic             preempt, retrig, hp_wrap;

  drum_sync_edge u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .drum  (drum),
    .hit   (hit)
  );

`ifdef PIEZO_DEBOUNCE_EN
  localparam int DEB_W = cnt_width(DEB_CYCLES + 1);

  logic [DEB_W-1:0] lock_q [NUM_PADS];
  logic [DEB_W-1:0] lock_d [NUM_PADS];
  logic             accept;

  // A hit is accepted when it starts, preempts or retriggers a tone; only then is its pad locked out.
  always_comb begin
    accept = win_valid && ((state_q == IDLE) || ((state_q == PLAY) && (win_idx <= pad_q)));
    for (int i = 0; i < NUM_PADS; i++) begin
      hit_ok[i] = hit[i] & (lock_q[i] == '0);
      if (accept && (win_idx == pad_idx_t'(i))) begin
        lock_d[i] = DEB_W'(DEB_CYCLES);
      end else if (lock_q[i] != '0) begin
        lock_d[i] = lock_q[i] - 1'b1;
      end else begin
        lock_d[i] = lock_q[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PADS; i++) begin
      if (!rst_n) lock_q[i] <= '0;
      else        lock_q[i] <= lock_d[i];
    end
  end
`else
  assign hit_ok = hit;
`endif

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (hit_ok[i]) begin
        win_valid = 1'b1;
        win_idx   = pad_idx_t'(i);
      end
    end
  end

  always_comb begin
    case (pad_q)
      2'd0:    hp_last = HP_LAST0;
      2'd1:    hp_last = HP_LAST1;
      2'd2:    hp_last = HP_LAST2;
      default: hp_last = HP_LAST3;
    endcase
  end

  // Retrigger leaves pitch and phase alone and only restarts the duration count.
  always_comb begin
    state_d   = state_q;
    pad_d     = pad_q;
    hp_cnt_d  = hp_cnt_q;
    dur_cnt_d = dur_cnt_q;
    gap_cnt_d = gap_cnt_q;
    piezo_d   = piezo_q;
    preempt   = win_valid && (win_idx < pad_q);
    retrig    = win_valid && (win_idx == pad_q);
    hp_wrap   = (hp_cnt_q == hp_last);

    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = PLAY;
          pad_d     = win_idx;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          piezo_d   = 1'b1;
        end
      end
      PLAY: begin
        if (preempt) begin
          pad_d     = win_idx;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          piezo_d   = 1'b1;
        end else if ((dur_cnt_q == DUR_LAST) && !retrig) begin
          state_d   = GAP;
          hp_cnt_d  = '0;
          dur_cnt_d = '0;
          gap_cnt_d = '0;
          piezo_d   = 1'b0;
        end else begin
          hp_cnt_d  = hp_wrap ? '0 : hp_cnt_q + 1'b1;
          piezo_d   = hp_wrap ? ~piezo_q : piezo_q;
          dur_cnt_d = retrig ? '0 : dur_cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d   = IDLE;
          gap_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pad_q     <= '0;
      hp_cnt_q  <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      piezo_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pad_q     <= pad_d;
      hp_cnt_q  <= hp_cnt_d;
      dur_cnt_q <= dur_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      piezo_q   <= piezo_d;
    end
  end

  assign piezo = piezo_q;
  assign led   = (state_q == PLAY) ? (4'b0001 << pad_q) : 4'b0000;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_piezo_tone_driver.sv
// Directed bench for piezo_tone_driver with short tone parameters.
module tb_piezo_tone_driver;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] drum  = 4'b0000;
  logic       piezo;
  logic [3:0] led;
  logic       busy;
  logic [5:0] obs;
  logic [5:0] exp_v;
  int         pass_cnt  = 0;
  int         total_cnt = 0;

`ifdef PIEZO_DEBOUNCE_EN
  localparam int DEB_END = 40;
`else
  localparam int DEB_END = 50;
`endif

  piezo_tone_driver #(
    .HP_BASE    (4),
    .HP_STEP    (2),
    .DUR_CYCLES (40),
    .GAP_CYCLES (8)
`ifdef PIEZO_DEBOUNCE_EN
    ,
    .DEB_CYCLES (20)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .drum  (drum),
    .piezo (piezo),
    .led   (led),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  assign obs = {piezo, led, busy};

  // Expected {piezo, led, busy} at play cycle t for a tone ending after end_t play cycles.
  function automatic logic [5:0] exp_out(int t, int pad, int hp, int end_t);
    logic [3:0] l;
    l = 4'b0001 << pad;
    if (t < end_t)     return {(((t / hp) % 2) == 0), l, 1'b1};
    if (t < end_t + 8) return 6'b000001;
    return 6'b000000;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drum  = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total_cnt++;
      if (piezo !== 1'b0) $display("[TB] FAIL reset_piezo cyc=%0d got %b exp 0", i, piezo);
      else pass_cnt++;
      total_cnt++;
      if (led !== 4'b0000) $display("[TB] FAIL reset_led cyc=%0d got %b exp 0000", i, led);
      else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("[TB] FAIL reset_busy cyc=%0d got %b exp 0", i, busy);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 6'b000000) $display("[TB] FAIL reset_held_no_tone cyc=%0d got %b exp 000000", i, obs);
      else pass_cnt++;
    end
    drum = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    drum = 4'b0100;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (busy !== 1'b0) $display("[TB] FAIL single_latency cyc=%0d busy=%b exp 0", i, busy);
      else pass_cnt++;
    end
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      exp_v = exp_out(t, 2, 8, 40);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL single t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
    end
    drum = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    drum = 4'b1010;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 55; t++) begin
      @(negedge clk);
      exp_v = exp_out(t, 1, 6, 40);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL simultaneous t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
    end
    drum = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_preempt();
    drum = 4'b1000;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 70; t++) begin
      @(negedge clk);
      exp_v = (t < 10) ? exp_out(t, 3, 10, 1000) : exp_out(t - 10, 0, 4, 40);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL preempt t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
      if (t == 7)  drum = 4'b1001;
      if (t == 15) drum = 4'b1101;
    end
    drum = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_retrigger();
    drum = 4'b0010;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 85; t++) begin
      @(negedge clk);
      exp_v = exp_out(t, 1, 6, 70);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL retrigger t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
      if (t == 2)  drum = 4'b0000;
      if (t == 27) drum = 4'b0010;
    end
    drum = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_debounce();
    drum = 4'b0010;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 65; t++) begin
      @(negedge clk);
      exp_v = exp_out(t, 1, 6, DEB_END);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL early_rehit t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
      if (t == 2) drum = 4'b0000;
      if (t == 7) drum = 4'b0010;
    end
    drum = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    drum = 4'b0001;
    repeat (2) @(negedge clk);
    for (int t = 0; t <= 15; t++) begin
      @(negedge clk);
      exp_v = exp_out(t, 0, 4, 40);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL pre_reset t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 6'b000000) $display("[TB] FAIL mid_reset cyc=%0d got %b exp 000000", i, obs);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if (obs !== 6'b000000) $display("[TB] FAIL post_reset_idle cyc=%0d got %b exp 000000", i, obs);
      else pass_cnt++;
    end
    drum = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_gap_hit();
    drum = 4'b0100;
    repeat (2) @(negedge clk);
    for (int t = 0; t < 66; t++) begin
      @(negedge clk);
      exp_v = exp_out(t, 2, 8, 40);
      total_cnt++;
      if (obs !== exp_v) $display("[TB] FAIL gap_hit t=%0d got %b exp %b", t, obs, exp_v);
      else pass_cnt++;
      if (t == 30) drum = 4'b0000;
      if (t == 41) drum = 4'b0001;
    end
    drum = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_preempt();
    test_retrigger();
    test_debounce();
    test_mid_reset();
    test_gap_hit();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
